// File: rtl/edge_pkg.sv
// Package: edge_pkg
// Shared types and helpers for the multi-channel edge detector.
//   edge_mode_t   per-channel edge qualification mode (OFF/RISE/FALL/BOTH)
//   DEF_FILT_LEN  default glitch-filter length in cycles
//   edge_qualify  maps a rise/fall pulse pair onto a qualified edge for a mode
package edge_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  localparam int DEF_FILT_LEN = 3;

  function automatic logic edge_qualify(input edge_mode_t mode_i,
                                        input logic       rise_i,
                                        input logic       fall_i);
    logic q;
    case (mode_i)
      EM_OFF:  q = 1'b0;
      EM_RISE: q = rise_i;
      EM_FALL: q = fall_i;
      EM_BOTH: q = rise_i | fall_i;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// Module: edge_filter_ch
// One channel of the edge detector: synchroniser chain, glitch filter and
// registered rise/fall pulse generation.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous reset, active-high
//   sig_i      raw asynchronous input
//   level_o    filtered level (registered)
//   posedge_o  1-cycle pulse in the cycle level_o rises (registered)
//   negedge_o  1-cycle pulse in the cycle level_o falls (registered)
//   rise_o     combinational: level_o will rise at the next clock edge
//   fall_o     combinational: level_o will fall at the next clock edge
module edge_filter_ch
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = DEF_FILT_LEN
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic level_o,
  output logic posedge_o,
  output logic negedge_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                FCNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic                   pos_q, neg_q;
  logic                   sync_out_s, differ_s, toggle_s;

  assign sync_out_s = sync_q[SYNC_STAGES-1];
  assign differ_s   = sync_out_s ^ level_q;
  // The level flips on the FILT_LEN-th consecutive differing sample.
  assign toggle_s   = differ_s && (fcnt_q == FCNT_LAST);
  assign rise_o     = toggle_s & ~level_q;
  assign fall_o     = toggle_s & level_q;

  // Filter next-state: count differing samples, restart on agreement or toggle
  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_q;
    if (!differ_s) begin
      fcnt_d = '0;
    end else if (toggle_s) begin
      fcnt_d  = '0;
      level_d = ~level_q;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // Synchroniser, filter state and registered edge pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      fcnt_q  <= '0;
      level_q <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      pos_q   <= rise_o;
      neg_q   <= fall_o;
    end
  end

  assign level_o   = level_q;
  assign posedge_o = pos_q;
  assign negedge_o = neg_q;

endmodule

// File: rtl/edge_detector_array.sv
// Module: edge_detector_array
// Multi-channel edge detector for the ADC timing path. Each channel is
// synchronised and glitch-filtered, produces rise/fall pulses, a
// mode-qualified EDGE pulse and a saturating edge counter.
// Optional build macro: TIMESTAMP_EN -- when defined, a free-running
// timestamp is captured into TS on every qualified edge; otherwise TS is 0.
// Ports:
//   CLK      system clock
//   RST      asynchronous reset, active-high
//   SIG      raw asynchronous inputs, one per channel
//   MODE     per-channel edge_mode_t, channel i at [2i+1:2i]
//   CNT_CLR  synchronous per-channel counter clear
//   LEVEL    filtered levels
//   POSEDGE  1-cycle pulse on filtered rise (ungated)
//   NEGEDGE  1-cycle pulse on filtered fall (ungated)
//   EDGE     1-cycle pulse on mode-qualified edge
//   CNT      per-channel count of EDGE pulses, saturating
//   TS       per-channel timestamp of the last EDGE
module edge_detector_array
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int CNT_W       = 16,
  parameter int TS_W        = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_CH-1:0]        SIG,
  input  logic [2*N_CH-1:0]      MODE,
  input  logic [N_CH-1:0]        CNT_CLR,
  output logic [N_CH-1:0]        LEVEL,
  output logic [N_CH-1:0]        POSEDGE,
  output logic [N_CH-1:0]        NEGEDGE,
  output logic [N_CH-1:0]        EDGE,
  output logic [N_CH*CNT_W-1:0]  CNT,
  output logic [N_CH*TS_W-1:0]   TS
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
    end
  end
`else
  assign TS = '0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             rise_s, fall_s;
    logic             edge_d, edge_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;

    edge_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_filt (
      .clk_i     (CLK),
      .rst_i     (RST),
      .sig_i     (SIG[i]),
      .level_o   (LEVEL[i]),
      .posedge_o (POSEDGE[i]),
      .negedge_o (NEGEDGE[i]),
      .rise_o    (rise_s),
      .fall_o    (fall_s)
    );

    // MODE is sampled on the same edge that toggles the level, so a later
    // MODE change cannot touch a pulse that is already registered.
    assign edge_d = edge_qualify(edge_mode_t'(MODE[2*i +: 2]), rise_s, fall_s);

    // Counter next-state: saturating increment; a clear coinciding with an
    // EDGE keeps that edge (count restarts at 1).
    always_comb begin
      cnt_inc_s = cnt_q;
      if (edge_q && (cnt_q != CNT_MAX)) begin
        cnt_inc_s = cnt_q + CNT_W'(1);
      end else begin
        cnt_inc_s = cnt_q;
      end
      if (CNT_CLR[i]) begin
        cnt_d = edge_q ? CNT_W'(1) : '0;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end

    // Qualified edge pulse and edge counter
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        edge_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        edge_q <= edge_d;
        cnt_q  <= cnt_d;
      end
    end

    assign EDGE[i]               = edge_q;
    assign CNT[i*CNT_W +: CNT_W] = cnt_q;

`ifdef TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Capture the pre-increment timestamp on the edge that registers EDGE
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        ts_q <= '0;
      end else if (edge_d) begin
        ts_q <= ts_cnt_q;
      end else begin
        ts_q <= ts_q;
      end
    end

    assign TS[i*TS_W +: TS_W] = ts_q;
`endif
  end

endmodule

// File: tb/tb_edge_detector_array.sv
// Testbench for edge_detector_array (N_CH=4, SYNC_STAGES=2, FILT_LEN=3, CNT_W=3).
// Expected pulses are queued when SIG is driven and checked by a monitor
// when the DUT emits them; counters and levels are checked inline per test.
module tb_edge_detector_array;
  import edge_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 3;
  localparam int TS_W  = 32;
  localparam int LAT   = 5;  // negedge of drive -> negedge where pulse is seen
  localparam int CMAX  = 7;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [N_CH-1:0]       SIG;
  logic [2*N_CH-1:0]     MODE;
  logic [N_CH-1:0]       CNT_CLR;
  logic [N_CH-1:0]       LEVEL, POSEDGE, NEGEDGE, EDGE;
  logic [N_CH*CNT_W-1:0] CNT;
  logic [N_CH*TS_W-1:0]  TS;

  typedef struct {
    int ch;
    int cyc;
    bit rise;
    bit edg;
  } pulse_t;

  pulse_t      exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_cnt[N_CH];
  logic [31:0] ts_m;
  logic [31:0] last_ts[N_CH];

  edge_detector_array #(
    .N_CH(N_CH), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .CLK(CLK), .RST(RST), .SIG(SIG), .MODE(MODE), .CNT_CLR(CNT_CLR),
    .LEVEL(LEVEL), .POSEDGE(POSEDGE), .NEGEDGE(NEGEDGE), .EDGE(EDGE),
    .CNT(CNT), .TS(TS)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference timestamp: counts clock edges since reset release
  always @(posedge CLK or posedge RST) begin
    if (RST) ts_m <= 32'd0;
    else     ts_m <= ts_m + 32'd1;
  end

  // Monitor: pop expected pulses as the DUT produces them
  always @(negedge CLK) begin
    pulse_t      p;
    logic [31:0] ts_exp;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_pulse: ch%0d got no pulse, required one at cycle %0d",
               exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      if (POSEDGE[ch] || NEGEDGE[ch] || EDGE[ch]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: ch%0d cycle %0d got pos=%b neg=%b edge=%b, required none",
                   ch, cyc, POSEDGE[ch], NEGEDGE[ch], EDGE[ch]);
        end else begin
          p = exp_q.pop_front();
          if (p.ch != ch || p.cyc != cyc || POSEDGE[ch] !== p.rise ||
              NEGEDGE[ch] !== !p.rise || EDGE[ch] !== p.edg) begin
            n_fail++;
            $display("FAIL pulse: got ch%0d cycle %0d pos=%b neg=%b edge=%b, required ch%0d cycle %0d pos=%b neg=%b edge=%b",
                     ch, cyc, POSEDGE[ch], NEGEDGE[ch], EDGE[ch],
                     p.ch, p.cyc, p.rise, !p.rise, p.edg);
          end
        end
        if (EDGE[ch]) begin
`ifdef TIMESTAMP_EN
          ts_exp = ts_m - 32'd1;
`else
          ts_exp = 32'd0;
`endif
          last_ts[ch] = ts_exp;
          n_checks++;
          if (TS[ch*TS_W +: TS_W] !== ts_exp) begin
            n_fail++;
            $display("FAIL ts_capture ch%0d: got %0d, required %0d",
                     ch, TS[ch*TS_W +: TS_W], ts_exp);
          end
        end
      end
    end
  end

  // Drive one filtered-length transition and queue its expected pulse
  task automatic toggle(input int ch, input logic val);
    pulse_t p;
    SIG[ch] = val;
    p.ch   = ch;
    p.cyc  = cyc + LAT;
    p.rise = val;
    p.edg  = val ? MODE[2*ch] : MODE[2*ch+1];
    exp_q.push_back(p);
    if (p.edg && exp_cnt[ch] < CMAX) exp_cnt[ch]++;
  endtask

  task automatic clr_all();
    @(negedge CLK);
    CNT_CLR = 4'hF;
    @(negedge CLK);
    CNT_CLR = 4'h0;
    for (int ch = 0; ch < N_CH; ch++) exp_cnt[ch] = 0;
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d pending pulses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cnt(input string name, input int ch);
    n_checks++;
    if (CNT[ch*CNT_W +: CNT_W] !== 3'(exp_cnt[ch])) begin
      n_fail++;
      $display("FAIL %s_cnt ch%0d: got %0d, required %0d",
               name, ch, CNT[ch*CNT_W +: CNT_W], exp_cnt[ch]);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; SIG = 4'h0; MODE = 8'h00; CNT_CLR = 4'h0;
    for (int ch = 0; ch < N_CH; ch++) begin exp_cnt[ch] = 0; last_ts[ch] = 32'd0; end
    repeat (5) @(negedge CLK);
    n_checks++;
    if ({LEVEL, POSEDGE, NEGEDGE, EDGE, CNT, TS} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got level=%h cnt=%h, required all zero", LEVEL, CNT);
    end
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    n_checks++;
    if ({LEVEL, POSEDGE, NEGEDGE, EDGE, CNT, TS} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got level=%h cnt=%h, required all zero", LEVEL, CNT);
    end
  endtask

  task automatic test_single_rise();
    MODE[1:0] = EM_RISE;
    @(negedge CLK);
    toggle(0, 1'b1);
    repeat (8) @(negedge CLK);
    n_checks++;
    if (LEVEL[0] !== 1'b1) begin
      n_fail++; $display("FAIL rise_level: got %b, required 1", LEVEL[0]);
    end
    check_cnt("rise", 0);
    toggle(0, 1'b0);
    repeat (8) @(negedge CLK);
    n_checks++;
    if (LEVEL[0] !== 1'b0) begin
      n_fail++; $display("FAIL fall_level: got %b, required 0", LEVEL[0]);
    end
    check_cnt("fall_ungated", 0);
    n_checks++;
    if (TS[TS_W-1:0] !== last_ts[0]) begin
      n_fail++; $display("FAIL ts_hold: got %0d, required %0d", TS[TS_W-1:0], last_ts[0]);
    end
    check_drained("single_rise");
  endtask

  task automatic test_glitch();
    MODE[3:2] = EM_BOTH;
    @(negedge CLK);
    SIG[1] = 1'b1;
    repeat (2) @(negedge CLK);
    SIG[1] = 1'b0;
    repeat (10) @(negedge CLK);
    n_checks++;
    if (LEVEL[1] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_level: got %b, required 0", LEVEL[1]);
    end
    check_cnt("glitch", 1);
    // Exactly FILT_LEN cycles high is just long enough to pass
    toggle(1, 1'b1);
    repeat (3) @(negedge CLK);
    toggle(1, 1'b0);
    repeat (10) @(negedge CLK);
    check_cnt("min_width", 1);
    check_drained("glitch");
  endtask

  task automatic test_square();
    edge_mode_t modes[3] = '{EM_BOTH, EM_FALL, EM_OFF};
    int         want[3]  = '{6, 3, 0};
    for (int m = 0; m < 3; m++) begin
      clr_all();
      MODE[5:4] = modes[m];
      for (int per = 0; per < 3; per++) begin
        toggle(2, 1'b1);
        repeat (10) @(negedge CLK);
        toggle(2, 1'b0);
        repeat (10) @(negedge CLK);
      end
      repeat (8) @(negedge CLK);
      n_checks++;
      if (CNT[2*CNT_W +: CNT_W] !== 3'(want[m])) begin
        n_fail++;
        $display("FAIL square_cnt mode%0d: got %0d, required %0d",
                 m, CNT[2*CNT_W +: CNT_W], want[m]);
      end
      check_drained("square");
    end
  endtask

  task automatic test_simultaneous();
    MODE = {EM_BOTH, EM_BOTH, EM_BOTH, EM_BOTH};
    clr_all();
    @(negedge CLK);
    for (int ch = 0; ch < N_CH; ch++) toggle(ch, 1'b1);
    repeat (8) @(negedge CLK);
    n_checks++;
    if (LEVEL !== 4'hF) begin
      n_fail++; $display("FAIL simul_level: got %h, required f", LEVEL);
    end
    for (int ch = 0; ch < N_CH; ch++) toggle(ch, 1'b0);
    repeat (8) @(negedge CLK);
    for (int ch = 0; ch < N_CH; ch++) check_cnt("simul", ch);
    check_drained("simul");
  endtask

  task automatic test_saturate();
    MODE[7:6] = EM_BOTH;
    clr_all();
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      toggle(3, (k % 2 == 0) ? 1'b1 : 1'b0);
      repeat (6) @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    check_cnt("saturate", 3);
    toggle(3, 1'b0);
    repeat (LAT) @(negedge CLK);
    // This cycle carries EDGE[3]; the clear must keep that edge
    CNT_CLR[3] = 1'b1;
    exp_cnt[3] = 1;
    @(negedge CLK);
    CNT_CLR[3] = 1'b0;
    repeat (3) @(negedge CLK);
    check_cnt("clr_on_edge", 3);
    check_drained("saturate");
  endtask

  task automatic test_reset_mid();
    pulse_t p;
    MODE[1:0] = EM_RISE;
    @(negedge CLK);
    SIG[0] = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({LEVEL, POSEDGE, NEGEDGE, EDGE, CNT, TS} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got level=%h cnt=%h, required all zero", LEVEL, CNT);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) exp_cnt[ch] = 0;
    exp_cnt[0] = 1;
    p.ch = 0; p.cyc = cyc + LAT; p.rise = 1'b1; p.edg = 1'b1;
    exp_q.push_back(p);
    repeat (8) @(negedge CLK);
    n_checks++;
    if (LEVEL[0] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_level: got %b, required 1", LEVEL[0]);
    end
    check_cnt("post_reset", 0);
    check_drained("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_square();
    test_simultaneous();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
